// File: rtl/axis_to_fifo_writer.sv
// AXI-Stream slave to standard FIFO write-port bridge with a 2-entry skid buffer
// and tlast-delimited packet length / count reporting.
module axis_to_fifo_writer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              full,
  output logic [DATA_W-1:0] din,
  output logic              wr_en,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [LEN_W-1:0]  pkt_count
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned OCC_W = 2;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t             buf_q [DEPTH];
  logic              head_q;
  logic [OCC_W-1:0]  occ_q;
  logic [LEN_W-1:0]  run_len_q;

  logic              accept_c;
  logic              tail_c;
  beat_t             head_beat_c;
  logic [OCC_W-1:0]  occ_nxt_c;
  logic              head_nxt_c;
  logic [LEN_W-1:0]  len_inc_c;

  // Handshake, write strobe and buffer bookkeeping
  always_comb begin
    accept_c    = s_axis_tvalid && s_axis_tready;
    head_beat_c = buf_q[head_q];
    tail_c      = head_q ^ occ_q[0];
    wr_en       = rst_n && (occ_q != OCC_W'(0)) && !full;
    din         = head_beat_c.data;
    occ_nxt_c   = occ_q + OCC_W'(accept_c) - OCC_W'(wr_en);
    head_nxt_c  = head_q ^ wr_en;
    len_inc_c   = (run_len_q == {LEN_W{1'b1}}) ? run_len_q : run_len_q + LEN_W'(1);
  end

  // Buffer storage carries no reset; occupancy alone qualifies its contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rst_n && accept_c && (tail_c == 1'(i))) begin
        buf_q[i] <= '{last: s_axis_tlast, data: s_axis_tdata};
      end
    end
  end

  // Occupancy, head pointer and registered ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q         <= '0;
      head_q        <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      occ_q         <= occ_nxt_c;
      head_q        <= head_nxt_c;
      s_axis_tready <= (occ_nxt_c < OCC_W'(DEPTH));
    end
  end

  // Packet tracking happens on FIFO writes, not on stream accepts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_len_q <= '0;
      pkt_done  <= 1'b0;
      pkt_len   <= '0;
      pkt_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (wr_en) begin
        if (head_beat_c.last) begin
          pkt_len   <= len_inc_c;
          pkt_count <= pkt_count + LEN_W'(1);
          pkt_done  <= 1'b1;
          run_len_q <= '0;
        end else begin
          run_len_q <= len_inc_c;
        end
      end
    end
  end

endmodule
